addsub_pipe: RTL and testbench

//  Parametrised two-stage pipelined adder/subtractor with valid/ready handshake.

---
 rtl/addsub_pkg.sv | 28 ++
 rtl/addsub_pipe_cond_invert.sv | 18 +
 rtl/addsub_pipe.sv | 148 ++++++++++++++
 tb/tb_addsub_pipe.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared constants for the pipelined add/sub unit.
//  OP_ADD / OP_SUB : encodings of the mode input m
//  FLG_*           : bit positions of the status flags inside the packed
//                    flag register kept by addsub_pipe
//  pack_flags      : helper that assembles the packed flag vector
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int NUM_FLG = 4;
  localparam int FLG_C   = 0;
  localparam int FLG_V   = 1;
  localparam int FLG_Z   = 2;
  localparam int FLG_N   = 3;

  function automatic logic [NUM_FLG-1:0] pack_flags(input logic c, input logic v,
                                                   input logic z, input logic n);
    logic [NUM_FLG-1:0] f;
    f        = {NUM_FLG{1'b0}};
    f[FLG_C] = c;
    f[FLG_V] = v;
    f[FLG_Z] = z;
    f[FLG_N] = n;
    return f;
  endfunction

endpackage

// File: rtl/addsub_pipe_cond_invert.sv
// Conditional operand inverter for stage 1 of addsub_pipe.
// Ports:
//  m_i       : mode, OP_SUB selects one's complement of b_i
//  b_i       : operand B
//  flipped_o : b_i or ~b_i
module cond_invert
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             m_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] flipped_o
);

  assign flipped_o = (m_i == OP_SUB) ? ~b_i : b_i;

endmodule

// File: rtl/addsub_pipe.sv
// Two-stage pipelined adder/subtractor with valid/ready handshake.
// Stage 1 captures A, the conditioned B and the mode; stage 2 forms
// A + B' + m and registers the result together with the status flags.
// Optional feature: define ADDSUB_SAT_EN to saturate the result to the
// signed MIN/MAX on overflow; without it the result wraps.
// Ports:
//  clk, rst_n           : clock, asynchronous active-low reset
//  in_valid / in_ready  : input handshake for a, b, m
//  a, b                 : operands (WIDTH bits), m : 0 add, 1 subtract
//  out_valid / out_ready: output handshake for result and flags
//  result               : sum/difference
//  carry                : carry-out (no-borrow on subtract)
//  overflow             : signed overflow
//  zero, negative       : result == 0, result MSB
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int MSB = WIDTH - 1;

  logic               s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]   s1_a_q, s1_a_d;
  logic [WIDTH-1:0]   s1_b_q, s1_b_d;
  // The carry-in of the adder equals the registered mode, so one flop serves both.
  logic               s1_m_q, s1_m_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [NUM_FLG-1:0] flags_q, flags_d;

  logic [WIDTH-1:0]   b_flip_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH-1:0]   res_s;
  logic               ovf_s;
  logic               s1_load_s;
  logic               s2_adv_s;

  cond_invert #(.WIDTH(WIDTH)) u_cond_invert (
    .m_i       (m),
    .b_i       (b),
    .flipped_o (b_flip_s)
  );

  assign s2_adv_s  = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready  = !s1_valid_q || s2_adv_s;
  assign s1_load_s = in_valid && in_ready;

  assign sum_s = {1'b0, s1_a_q} + {1'b0, s1_b_q} + {{WIDTH{1'b0}}, s1_m_q};
  assign ovf_s = (s1_a_q[MSB] == s1_b_q[MSB]) && (sum_s[MSB] != s1_a_q[MSB]);

`ifdef ADDSUB_SAT_EN
  // Clamp toward the sign of A when the signed result overflowed.
  always_comb begin
    res_s = sum_s[WIDTH-1:0];
    if (ovf_s) begin
      if (s1_a_q[MSB]) begin
        res_s = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        res_s = {1'b0, {(WIDTH-1){1'b1}}};
      end
    end else begin
      res_s = sum_s[WIDTH-1:0];
    end
  end
`else
  assign res_s = sum_s[WIDTH-1:0];
`endif

  // Next-state for the stage-1 register and its valid bit.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_m_d     = s1_m_q;
    if (s1_load_s) begin
      s1_valid_d = 1'b1;
      s1_a_d     = a;
      s1_b_d     = b_flip_s;
      s1_m_d     = m;
    end else if (s2_adv_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Next-state for the output register; held while the consumer stalls.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    if (s2_adv_s) begin
      out_valid_d = 1'b1;
      result_d    = res_s;
      flags_d     = pack_flags(sum_s[WIDTH], ovf_s,
                               (res_s == {WIDTH{1'b0}}), res_s[MSB]);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= {WIDTH{1'b0}};
      s1_b_q      <= {WIDTH{1'b0}};
      s1_m_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      flags_q     <= {NUM_FLG{1'b0}};
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_m_q      <= s1_m_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = flags_q[FLG_C];
  assign overflow  = flags_q[FLG_V];
  assign zero      = flags_q[FLG_Z];
  assign negative  = flags_q[FLG_N];

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed testbench for addsub_pipe (WIDTH = 8). Expected values are
// hand-computed constants; saturated expectations apply when ADDSUB_SAT_EN
// is defined for the build.
module tb_addsub_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       m;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       carry;
  logic       overflow;
  logic       zero;
  logic       negative;

  int checks_cnt;
  int errors_cnt;

  addsub_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .m         (m),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Flags packed as {N, Z, V, C} for compact comparison.
  function automatic logic [3:0] flags_now();
    return {negative, zero, overflow, carry};
  endfunction

  // One isolated op with out_ready=1: present, transfer, then check two edges later.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic mv, input logic [7:0] exp_res, input logic [3:0] exp_flg);
    a = av; b = bv; m = mv; in_valid = 1'b1;
    check_eq({tag, "_in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    check_eq({tag, "_ov_early"}, out_valid, 0);
    step();
    check_eq({tag, "_out_valid"}, out_valid, 1);
    check_eq({tag, "_result"}, result, exp_res);
    check_eq({tag, "_flags"}, flags_now(), exp_flg);
    step();
    check_eq({tag, "_drained"}, out_valid, 0);
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    m         = 1'b0;
    out_ready = 1'b1;

    // 1. Reset and release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_result", result, 8'h00);
    check_eq("rst_flags", flags_now(), 4'b0000);

    // 2./3. Add and subtract, flags {N,Z,V,C}.
    run_op("add_5_3", 8'h05, 8'h03, 1'b0, 8'h08, 4'b0000);
    run_op("sub_5_7", 8'h05, 8'h07, 1'b1, 8'hFE, 4'b1000);
    run_op("sub_7_7", 8'h07, 8'h07, 1'b1, 8'h00, 4'b0101);
    run_op("add_ff_1", 8'hFF, 8'h01, 1'b0, 8'h00, 4'b0101);

    // 4. Signed overflow cases.
`ifdef ADDSUB_SAT_EN
    run_op("ovf_add", 8'h7F, 8'h01, 1'b0, 8'h7F, 4'b0010);
    run_op("ovf_sub", 8'h80, 8'h01, 1'b1, 8'h80, 4'b1011);
`else
    run_op("ovf_add", 8'h7F, 8'h01, 1'b0, 8'h80, 4'b1010);
    run_op("ovf_sub", 8'h80, 8'h01, 1'b1, 8'h7F, 4'b0011);
`endif

    // 5. Backpressure: three back-to-back ops with out_ready low.
    out_ready = 1'b0;
    a = 8'h0A; b = 8'h14; m = 1'b0; in_valid = 1'b1;   // op1 -> 0x1E
    step();
    check_eq("bp_ready_after1", in_ready, 1);
    a = 8'h50; b = 8'h10; m = 1'b1;                    // op2 -> 0x40
    step();
    check_eq("bp_ready_after2", in_ready, 0);
    check_eq("bp_valid_after2", out_valid, 1);
    check_eq("bp_res_op1", result, 8'h1E);
    a = 8'h33; b = 8'h44; m = 1'b0;                    // op3 -> 0x77, must wait
    step();
    check_eq("bp_hold_ready", in_ready, 0);
    check_eq("bp_hold_res", result, 8'h1E);
    check_eq("bp_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", in_ready, 1);
    step();                                            // pop op1, push op3
    in_valid = 1'b0;
    check_eq("bp_out2_valid", out_valid, 1);
    check_eq("bp_out2_res", result, 8'h40);
    step();
    check_eq("bp_out3_valid", out_valid, 1);
    check_eq("bp_out3_res", result, 8'h77);
    step();
    check_eq("bp_empty", out_valid, 0);

    // 6. Reset with two ops in flight.
    out_ready = 1'b0;
    a = 8'h01; b = 8'h02; m = 1'b0; in_valid = 1'b1;
    step();
    a = 8'h03; b = 8'h04;
    step();
    in_valid = 1'b0;
    check_eq("mid_full_valid", out_valid, 1);
    check_eq("mid_full_ready", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_result", result, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("post_rst_idle", out_valid, 0);
    end
    run_op("post_rst_op", 8'h20, 8'h22, 1'b0, 8'h42, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
